// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer for a small core: drives the
// instruction/data memory port, the PC, the instruction register and the register-file write strobe.
module cpu_sequencer #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] instr,
    input  logic [1:0]        dec_pc_sel,
    input  logic [ADDR_W-1:0] dec_target,
    input  logic [DATA_W-1:0] reg_target,
    input  logic              dec_mem_rd,
    input  logic              dec_mem_wr,
    input  logic [ADDR_W-1:0] dec_mem_addr,
    input  logic [DATA_W-1:0] dec_store_data,
    output logic              rf_we,
    output logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [31:0]       retired
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] next_pc_q;
    logic [ADDR_W-1:0] reg_pc;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              op_store;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] load_q;
    logic [31:0]       retired_q;
    logic              is_mem_op;
    logic              load_done;

    generate
        if (DATA_W >= ADDR_W) begin : g_trunc
            assign reg_pc = reg_target[ADDR_W-1:0];
        end else begin : g_zext
            assign reg_pc = {{(ADDR_W-DATA_W){1'b0}}, reg_target};
        end
    endgenerate

    assign is_mem_op = dec_mem_rd | dec_mem_wr;

    always_comb begin
        next_pc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        case (dec_pc_sel)
            2'b01:   next_pc = dec_target;
            2'b10:   next_pc = reg_pc;
            default: next_pc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        endcase
    end

    // A memory instruction parks its target PC in next_pc_q so the decoder
    // inputs only need to stay valid during EXEC for control flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc_q      <= RESET_PC;
            next_pc_q <= '0;
            op_addr   <= '0;
            op_wdata  <= '0;
            op_store  <= 1'b0;
            instr_q   <= '0;
            load_q    <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        instr_q <= mem_rdata;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (dec_pc_sel == 2'b11) begin
                        state <= HALT;
                    end else if (is_mem_op) begin
                        op_addr   <= dec_mem_addr;
                        op_wdata  <= dec_store_data;
                        op_store  <= dec_mem_wr;
                        next_pc_q <= next_pc;
                        state     <= MEM;
                    end else begin
                        pc_q      <= next_pc;
                        retired_q <= retired_q + 32'd1;
                        state     <= FETCH;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (!op_store) begin
                            load_q <= mem_rdata;
                        end
                        pc_q      <= next_pc_q;
                        retired_q <= retired_q + 32'd1;
                        state     <= FETCH;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    // Strobes are gated with rst so nothing is requested or written while reset is held.
    assign load_done = !rst && (state == MEM) && mem_ready && !op_store;
    assign mem_req   = !rst && ((state == FETCH) || (state == MEM));
    assign mem_we    = !rst && (state == MEM) && op_store;
    assign mem_addr  = (state == MEM) ? op_addr : pc_q;
    assign mem_wdata = op_wdata;
    assign rf_we     = load_done ||
                       (!rst && (state == EXEC) && (dec_pc_sel != 2'b11) && !is_mem_op);
    assign load_data = load_done ? mem_rdata : load_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign halted    = (state == HALT);
    assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: the bench plays both memory and decoder,
// stepping one clock at a time and checking against hand-computed values.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [15:0] instr;
   logic [1:0]  dec_pc_sel;
   logic [15:0] dec_target;
   logic [15:0] reg_target;
   logic        dec_mem_rd;
   logic        dec_mem_wr;
   logic [15:0] dec_mem_addr;
   logic [15:0] dec_store_data;
   logic        rf_we;
   logic [15:0] load_data;
   logic [15:0] pc;
   logic        halted;
   logic [31:0] retired;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cpu_sequencer #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr),
      .dec_pc_sel(dec_pc_sel), .dec_target(dec_target), .reg_target(reg_target),
      .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_mem_addr(dec_mem_addr),
      .dec_store_data(dec_store_data), .rf_we(rf_we), .load_data(load_data),
      .pc(pc), .halted(halted), .retired(retired)
   );

   // Drive every memory/decoder input for the current cycle and let it settle.
   task automatic applyStimulus(input logic rdy, input logic [15:0] rdata, input logic [1:0] sel,
                                input logic [15:0] tgt, input logic [15:0] regt,
                                input logic rd, input logic wr,
                                input logic [15:0] maddr, input logic [15:0] sdata);
      mem_ready      = rdy;
      mem_rdata      = rdata;
      dec_pc_sel     = sel;
      dec_target     = tgt;
      reg_target     = regt;
      dec_mem_rd     = rd;
      dec_mem_wr     = wr;
      dec_mem_addr   = maddr;
      dec_store_data = sdata;
      #1;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Complete a zero-wait fetch of the expected address.
   task automatic doFetch(input string tag, input logic [15:0] addr, input logic [15:0] word);
      applyStimulus(1'b1, word, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput({tag, "_req"}, 32'(mem_req), 32'd1);
      checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      tick();
      checkOutput("rst_req", 32'(mem_req), 32'd0);
      checkOutput("rst_we", 32'(mem_we), 32'd0);
      checkOutput("rst_rfwe", 32'(rf_we), 32'd0);
      checkOutput("rst_pc", 32'(pc), 32'h0);
      checkOutput("rst_retired", retired, 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_instr", 32'(instr), 32'h0);
      checkOutput("rst_load", 32'(load_data), 32'h0);

      // ALU instruction at address 0, sequential PC.
      rst = 1'b0;
      doFetch("alu_fetch", 16'h0000, 16'h0001);
      applyStimulus(1'b1, 16'hDEAD, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("alu_exec_req", 32'(mem_req), 32'd0);
      checkOutput("alu_exec_rfwe", 32'(rf_we), 32'd1);
      checkOutput("alu_exec_instr", 32'(instr), 32'h0001);
      tick();
      checkOutput("alu_retired", retired, 32'd1);

      // Load from 0x0040 with three wait states.
      doFetch("ld_fetch", 16'h0001, 16'hA000);
      applyStimulus(1'b0, 16'h0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
      checkOutput("ld_exec_rfwe", 32'(rf_we), 32'd0);
      checkOutput("ld_exec_req", 32'(mem_req), 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 16'h1111, 2'b01, 16'h7777, 16'h0, 1'b0, 1'b1, 16'h9999, 16'h5555);
         checkOutput("ld_wait_req", 32'(mem_req), 32'd1);
         checkOutput("ld_wait_addr", 32'(mem_addr), 32'h0040);
         checkOutput("ld_wait_we", 32'(mem_we), 32'd0);
         checkOutput("ld_wait_rfwe", 32'(rf_we), 32'd0);
         tick();
      end
      applyStimulus(1'b1, 16'hBEEF, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("ld_done_addr", 32'(mem_addr), 32'h0040);
      checkOutput("ld_done_rfwe", 32'(rf_we), 32'd1);
      checkOutput("ld_done_data", 32'(load_data), 32'hBEEF);
      checkOutput("ld_done_instr", 32'(instr), 32'hA000);
      tick();
      checkOutput("ld_after_rfwe", 32'(rf_we), 32'd0);
      checkOutput("ld_after_load", 32'(load_data), 32'hBEEF);
      checkOutput("ld_retired", retired, 32'd2);

      // Store 0x1234 to 0x00FF; both rd and wr set means store.
      doFetch("st_fetch", 16'h0002, 16'hB000);
      applyStimulus(1'b1, 16'h0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b1, 16'h00FF, 16'h1234);
      checkOutput("st_exec_rfwe", 32'(rf_we), 32'd0);
      tick();
      applyStimulus(1'b1, 16'h4321, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("st_req", 32'(mem_req), 32'd1);
      checkOutput("st_we", 32'(mem_we), 32'd1);
      checkOutput("st_addr", 32'(mem_addr), 32'h00FF);
      checkOutput("st_wdata", 32'(mem_wdata), 32'h1234);
      checkOutput("st_rfwe", 32'(rf_we), 32'd0);
      tick();
      checkOutput("st_load_kept", 32'(load_data), 32'hBEEF);
      checkOutput("st_retired", retired, 32'd3);

      // Absolute jump to 0xFFFF, wrap to 0x0000, then register jump to 0x0010.
      doFetch("jmp_fetch", 16'h0003, 16'hC000);
      applyStimulus(1'b1, 16'h0, 2'b01, 16'hFFFF, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("jmp_rfwe", 32'(rf_we), 32'd1);
      tick();
      doFetch("top_fetch", 16'hFFFF, 16'h0002);
      applyStimulus(1'b1, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      doFetch("wrap_fetch", 16'h0000, 16'h0003);
      applyStimulus(1'b1, 16'h0, 2'b10, 16'h0, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
      tick();
      checkOutput("rjmp_retired", retired, 32'd6);

      // Stalled fetch at 0x0010, then halt.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
         checkOutput("stall_req", 32'(mem_req), 32'd1);
         checkOutput("stall_addr", 32'(mem_addr), 32'h0010);
         tick();
      end
      doFetch("halt_fetch", 16'h0010, 16'hF000);
      applyStimulus(1'b1, 16'h0, 2'b11, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("halt_exec_rfwe", 32'(rf_we), 32'd0);
      tick();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(i[0], 16'h0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
         checkOutput("halt_req", 32'(mem_req), 32'd0);
         checkOutput("halt_flag", 32'(halted), 32'd1);
         checkOutput("halt_rfwe", 32'(rf_we), 32'd0);
         tick();
      end
      checkOutput("halt_pc", 32'(pc), 32'h0010);
      checkOutput("halt_retired", retired, 32'd6);

      // Reset pulse leaves HALT and restarts at RESET_PC.
      rst = 1'b1;
      tick();
      applyStimulus(1'b1, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("rst2_req", 32'(mem_req), 32'd0);
      checkOutput("rst2_halted", 32'(halted), 32'd0);
      checkOutput("rst2_retired", retired, 32'd0);
      rst = 1'b0;
      doFetch("rst2_fetch", 16'h0000, 16'hB100);

      // Reset in the middle of a waiting store.
      applyStimulus(1'b0, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 16'h00FF, 16'h5555);
      tick();
      applyStimulus(1'b0, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("abort_pre_we", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("abort_rst_req", 32'(mem_req), 32'd0);
      checkOutput("abort_rst_we", 32'(mem_we), 32'd0);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
      checkOutput("abort_req", 32'(mem_req), 32'd1);
      checkOutput("abort_we", 32'(mem_we), 32'd0);
      checkOutput("abort_addr", 32'(mem_addr), 32'h0000);
      checkOutput("abort_retired", retired, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, data and instruction width in bits.
REQ-002 Parameter ADDR_W, default 16, memory address and PC width in bits.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mem_req  out  1  memory transaction request.
REQ-007 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 mem_addr  out  ADDR_W  transaction address.
REQ-009 mem_wdata  out  DATA_W  store data.
REQ-010 mem_rdata  in  DATA_W  read data; valid in the mem_ready cycle.
REQ-011 mem_ready  in  1  memory completes the current transaction this cycle.
REQ-012 instr  out  DATA_W  instruction register, drives the decoder.
REQ-013 dec_pc_sel  in  2  00 increment, 01 dec_target, 10 reg_target, 11 halt.
REQ-014 dec_target  in  ADDR_W  absolute branch target from the instruction.
REQ-015 reg_target  in  DATA_W  branch target from the register file.
REQ-016 dec_mem_rd / dec_mem_wr  in  1 each  instruction is a load / store.
REQ-017 dec_mem_addr  in  ADDR_W  load/store address.
REQ-018 dec_store_data  in  DATA_W  store data.
REQ-019 rf_we  out  1  register-file write-enable pulse.
REQ-020 load_data  out  DATA_W  load result to the register file.
REQ-021 pc  out  ADDR_W  current program counter.
REQ-022 halted  out  1  core is in HALT.
REQ-023 retired  out  32  count of retired instructions.

Function
REQ-024 The block SHALL implement states FETCH, EXEC, MEM, HALT.
REQ-025 FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold all three stable until mem_ready=1; on mem_ready, instr<=mem_rdata, go to EXEC.
REQ-026 EXEC lasts exactly one cycle, mem_req=0; next_pc SHALL be latched: 00 pc+1 (mod 2^ADDR_W), 01 dec_target, 10 reg_target[ADDR_W-1:0] (zero-extended if DATA_W<ADDR_W).
REQ-027 EXEC with dec_pc_sel=11: go to HALT; no rf_we, pc unchanged, retired unchanged.
REQ-028 EXEC with dec_mem_rd or dec_mem_wr: latch dec_mem_addr, dec_store_data and the op type, go to MEM; rf_we=0.
REQ-029 EXEC with no memory op: rf_we=1 for that cycle, pc<=next_pc, retired+1, go to FETCH.
REQ-030 dec_mem_rd and dec_mem_wr both 1: treated as store; read ignored.
REQ-031 MEM: mem_req=1, mem_addr/mem_wdata from latched values, mem_we=1 for a store; outputs stable until mem_ready=1.
REQ-032 MEM on mem_ready: for a load, rf_we=1 and load_data=mem_rdata in that same cycle; for a store, rf_we=0; then pc<=next_pc, retired+1, go to FETCH.
REQ-033 instr SHALL remain unchanged from EXEC through MEM so decoder outputs stay valid for the load write-back.
REQ-034 mem_ready while mem_req=0 SHALL be ignored.
REQ-035 rf_we SHALL never be 1 outside EXEC or the completing MEM cycle.
REQ-036 HALT: mem_req=0, rf_we=0, halted=1; exited only by rst.
REQ-037 retired wraps from 2^32-1 to 0.
REQ-038 Minimum latency: non-memory instruction 2 cycles, load/store 3 cycles; each mem_ready=0 cycle adds one.

Reset
REQ-039 On rst=1 at a clock edge: state=FETCH, pc=RESET_PC, instr=0, retired=0, halted=0, load_data=0, latched address/data=0.
REQ-040 While rst=1, mem_req=0, mem_we=0, rf_we=0.
REQ-041 Reset during an outstanding FETCH or MEM SHALL abandon the transaction: no rf_we, no write to mem, new FETCH of RESET_PC on the first cycle after rst deasserts.

Verification
REQ-042 mem_ready tied 1, ALU instr at 0, pc_sel=00 -> mem_req at cycle 0, rf_we pulse at cycle 1, fetch of addr 1 at cycle 2, retired=1.
REQ-043 Load addr 0x0040, mem_ready delayed 3 cycles -> mem_addr=0x0040, mem_we=0 held 4 cycles, rf_we and load_data=0xBEEF in the ready cycle, next fetch at pc+1.
REQ-044 Store 0x1234 to 0x00FF with mem_ready=1 -> one cycle mem_req=1, mem_we=1, mem_wdata=0x1234, no rf_we.
REQ-045 pc=0xFFFF, pc_sel=00 -> next fetch address 0x0000; pc_sel=10 with reg_target=0x0010 -> fetch 0x0010.
REQ-046 pc_sel=11 -> halted=1, mem_req stays 0 for 20 cycles; rst pulse -> fetch of RESET_PC.
REQ-047 rst asserted in MEM of a store before mem_ready -> mem_req=0 after the edge, no write, retired=0.
